// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard control for a 5-stage MIPS pipeline with a multi-cycle mult/div unit.
//   - EX-stage forwarding select per source operand (combinational).
//   - Load-use detection in ID (combinational).
//   - Countdown scoreboard for the mult/div unit (busy, done pulse, sticky
//     overlap error).
//   - Stall/flush generation, with the external bus wait taking priority.
//   - Saturating count of cycles in which ID is held, for performance debug.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   src_idx_d/_e      packed ID/EX source register indices (operand 0 in LSBs)
//   reg_write_*_e/m/w write enable / destination of EX, MEM, WB instructions
//   mem_to_reg_e/m    EX / MEM instruction is a load
//   md_use_d          ID instruction reads HI/LO or is mult/div
//   md_start_e        EX requests a mult/div start; md_is_div_e selects divide
//   ext_stall         memory/bus wait, freezes the whole pipeline
//   forward_e         per-operand select: 0 regfile, 1 MEM ALU result, 2 WB result
//   stall_f/d/e/m     hold PC, IF/ID, ID/EX, EX/MEM
//   flush_e           bubble into ID/EX
//   md_busy, md_done  unit occupied / one-cycle completion pulse
//   md_overlap_err    sticky: start accepted while busy
//   stall_cycles      saturating count of cycles with stall_d=1
module hazard_unit_mc #(
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC*5-1:0] src_idx_d,
  input  logic [NUM_SRC*5-1:0] src_idx_e,
  input  logic                 reg_write_en_e,
  input  logic [4:0]           reg_write_dst_e,
  input  logic                 mem_to_reg_e,
  input  logic                 reg_write_en_m,
  input  logic [4:0]           reg_write_dst_m,
  input  logic                 mem_to_reg_m,
  input  logic                 reg_write_en_w,
  input  logic [4:0]           reg_write_dst_w,
  input  logic                 md_use_d,
  input  logic                 md_start_e,
  input  logic                 md_is_div_e,
  input  logic                 ext_stall,
  output logic [NUM_SRC*2-1:0] forward_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_e,
  output logic                 md_busy,
  output logic                 md_done,
  output logic                 md_overlap_err,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int MDC_W = $clog2(DIV_LAT + 1);
  localparam logic [MDC_W-1:0] L_MUL = MDC_W'(MUL_LAT);
  localparam logic [MDC_W-1:0] L_DIV = MDC_W'(DIV_LAT);
  localparam logic [MDC_W-1:0] L_ONE = MDC_W'(1);

  logic [MDC_W-1:0] r_md_cnt;
  logic             r_md_done;
  logic             r_md_ovl;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_src_hit_e;
  logic w_lu;
  logic w_accept;
  logic w_busy;
  logic w_mdh;

  // Forwarding: MEM has priority over WB; a load in MEM has no data yet,
  // so it can only be picked up once it reaches WB. r0 is never forwarded.
  always_comb begin
    forward_e = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_idx_e[i*5 +: 5] != 5'd0) begin
        if (reg_write_en_m && !mem_to_reg_m &&
            (reg_write_dst_m == src_idx_e[i*5 +: 5])) begin
          forward_e[i*2 +: 2] = 2'd1;
        end else if (reg_write_en_w &&
                     (reg_write_dst_w == src_idx_e[i*5 +: 5])) begin
          forward_e[i*2 +: 2] = 2'd2;
        end
      end
    end
  end

  // Load-use: any non-zero ID source matching the destination of a load in EX.
  always_comb begin
    w_src_hit_e = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((src_idx_d[i*5 +: 5] != 5'd0) &&
          (src_idx_d[i*5 +: 5] == reg_write_dst_e)) begin
        w_src_hit_e = 1'b1;
      end
    end
  end

  assign w_lu     = reg_write_en_e & mem_to_reg_e & w_src_hit_e;
  // A start in EX is lost if the pipeline is frozen; EX will present it again.
  assign w_accept = md_start_e & ~ext_stall;
  assign w_busy   = (r_md_cnt != '0);
  // The starting op itself also blocks a HI/LO reader sitting in ID.
  assign w_mdh    = md_use_d & (w_busy | w_accept);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_e = 1'b0;
    if (ext_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (w_lu || w_mdh) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Scoreboard countdown keeps running during ext_stall: the unit itself is
  // not frozen by the bus wait. A start while busy restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt  <= '0;
      r_md_done <= 1'b0;
      r_md_ovl  <= 1'b0;
    end else begin
      r_md_done <= !w_accept && (r_md_cnt == L_ONE);
      if (w_accept) begin
        r_md_cnt <= md_is_div_e ? L_DIV : L_MUL;
        if (w_busy) begin
          r_md_ovl <= 1'b1;
        end
      end else if (w_busy) begin
        r_md_cnt <= r_md_cnt - L_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall_d && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign md_busy        = w_busy;
  assign md_done        = r_md_done;
  assign md_overlap_err = r_md_ovl;
  assign stall_cycles   = r_stall_cnt;

endmodule
